// File: rtl/fifo_stream_drain.sv
// fifo_stream_drain
//   Drains the read port of the width-converting sync FIFO (one-cycle read
//   latency) into a valid/ready stream. It uses a 2-entry prefetch buffer,
//   so the stream runs at one beat per cycle and no data is lost under
//   backpressure. A beat counter frames fixed-length bursts of BURST_LEN beats.
//
// Ports
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   clr          synchronous flush, overrides everything else
//   fifo_rempty  FIFO empty flag
//   fifo_rd_en   FIFO read strobe
//   fifo_dout    FIFO read data, valid the cycle after an accepted read
//   m_valid, m_ready, m_data   output stream
//   m_last       final beat of the current burst
//   beat_cnt     index of the current beat within its burst
//   burst_done   one-cycle pulse after the last beat of a burst pops
module fifo_stream_drain #(
    parameter int unsigned DW        = 8,
    parameter int unsigned BURST_LEN = 4,
    localparam int unsigned CW       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          fifo_rempty,
    output logic          fifo_rd_en,
    input  logic [DW-1:0] fifo_dout,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    output logic [CW-1:0] beat_cnt,
    output logic          burst_done
);

    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

    logic [1:0]    occ_q, occ_d;
    logic          inflight_q;
    logic          wr_ptr_q, rd_ptr_q;
    logic [DW-1:0] buf_q [2];
    logic [CW-1:0] beat_q, beat_d;
    logic          burst_done_q;
    logic          pop;
    logic [1:0]    credit;

    assign m_valid    = (occ_q != 2'd0);
    assign m_data     = buf_q[rd_ptr_q];
    assign pop        = m_valid && m_ready;
    assign m_last     = m_valid && (beat_q == LAST_BEAT);
    assign beat_cnt   = beat_q;
    assign burst_done = burst_done_q;

    // Words held plus the word in flight never exceed the two buffer slots.
    // A pop this cycle frees one slot, so a read may still be issued when the
    // credit count is already 2. This gives m_ready a combinational path to
    // fifo_rd_en.
    assign credit     = occ_q + {1'b0, inflight_q};
    assign fifo_rd_en = rst_n && !clr && !fifo_rempty && ((credit < 2'd2) || pop);

    always_comb begin
        occ_d  = occ_q + {1'b0, inflight_q} - {1'b0, pop};
        beat_d = beat_q;
        if (pop) begin
            beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q        <= 2'd0;
            inflight_q   <= 1'b0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            buf_q[0]     <= '0;
            buf_q[1]     <= '0;
            beat_q       <= '0;
            burst_done_q <= 1'b0;
        end else if (clr) begin
            // Clearing inflight drops any word still returning from the FIFO.
            occ_q        <= 2'd0;
            inflight_q   <= 1'b0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            beat_q       <= '0;
            burst_done_q <= 1'b0;
        end else begin
            occ_q        <= occ_d;
            inflight_q   <= fifo_rd_en;
            if (inflight_q) begin
                buf_q[wr_ptr_q] <= fifo_dout;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            beat_q       <= beat_d;
            burst_done_q <= pop && m_last;
        end
    end

endmodule

// File: tb/tb_fifo_stream_drain.sv
`timescale 1ns/1ps
module tb_fifo_stream_drain;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance 0: BURST_LEN = 4
    logic       clr0, rempty0, rd_en0, m_valid0, m_ready0, m_last0, done0;
    logic [7:0] dout0, m_data0;
    logic [1:0] beat0;
    // Instance 1: BURST_LEN = 1
    logic       clr1, rempty1, rd_en1, m_valid1, m_ready1, m_last1, done1;
    logic [7:0] dout1, m_data1;
    logic [0:0] beat1;

    fifo_stream_drain #(.DW(8), .BURST_LEN(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr0), .fifo_rempty(rempty0), .fifo_rd_en(rd_en0),
        .fifo_dout(dout0), .m_valid(m_valid0), .m_ready(m_ready0), .m_data(m_data0),
        .m_last(m_last0), .beat_cnt(beat0), .burst_done(done0)
    );

    fifo_stream_drain #(.DW(8), .BURST_LEN(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr1), .fifo_rempty(rempty1), .fifo_rd_en(rd_en1),
        .fifo_dout(dout1), .m_valid(m_valid1), .m_ready(m_ready1), .m_data(m_data1),
        .m_last(m_last1), .beat_cnt(beat1), .burst_done(done1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // FIFO models: one-cycle read latency
    logic [7:0] mem0 [64];
    logic [7:0] mem1 [64];
    int wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0;
    assign rempty0 = (wr0 == rd0);
    assign rempty1 = (wr1 == rd1);

    always @(posedge clk) begin
        if (rd_en0) begin
            check("rd_on_nonempty0", 32'(rd0 != wr0), 32'd1);
            if (rd0 != wr0) begin
                dout0 <= mem0[rd0];
                rd0   <= rd0 + 1;
            end
        end
        if (rd_en1) begin
            check("rd_on_nonempty1", 32'(rd1 != wr1), 32'd1);
            if (rd1 != wr1) begin
                dout1 <= mem1[rd1];
                rd1   <= rd1 + 1;
            end
        end
    end

    // Scoreboards: {data, last, beat}
    logic [10:0] sb0 [$];
    logic [7:0]  sb1 [$];
    logic [1:0]  exp_beat0 = 2'd0;

    task automatic fifo_put0(input logic [7:0] d);
        mem0[wr0] = d;
        wr0++;
    endtask

    task automatic expect0(input logic [7:0] d);
        sb0.push_back({d, (exp_beat0 == 2'd3), exp_beat0});
        exp_beat0 = exp_beat0 + 2'd1;
    endtask

    task automatic push0(input logic [7:0] d);
        fifo_put0(d);
        expect0(d);
    endtask

    task automatic push1(input logic [7:0] d);
        mem1[wr1] = d;
        wr1++;
        sb1.push_back(d);
    endtask

    // Monitors sample on the falling edge; stimulus changes 1ns after the rising edge.
    logic [7:0] hold_data0;
    logic       stall0     = 1'b0;
    logic       done_next0 = 1'b0;
    int         done_cnt0  = 0;
    int         done_cnt1  = 0;

    always @(negedge clk) begin
        logic [10:0] e;
        if (!rst_n) begin
            stall0     = 1'b0;
            done_next0 = 1'b0;
        end else begin
            check("burst_done", done0, done_next0);
            if (done0) done_cnt0++;
            if (stall0) begin
                check("hold_valid", m_valid0, 1'b1);
                check("hold_data", m_data0, hold_data0);
            end
            if (m_valid0 && m_ready0) begin
                check("sb0_nonempty", 32'(sb0.size() != 0), 32'd1);
                if (sb0.size() != 0) begin
                    e = sb0.pop_front();
                    check("beat_data", m_data0, e[10:3]);
                    check("beat_last", m_last0, e[2]);
                    check("beat_cnt", beat0, e[1:0]);
                end
            end
            done_next0 = m_valid0 && m_ready0 && m_last0 && !clr0;
            stall0     = m_valid0 && !m_ready0 && !clr0;
            hold_data0 = m_data0;
        end
    end

    always @(negedge clk) begin
        logic [7:0] e;
        if (rst_n) begin
            check("bl1_beat_cnt", beat1, 1'b0);
            if (done1) done_cnt1++;
            if (m_valid1 && m_ready1) begin
                check("sb1_nonempty", 32'(sb1.size() != 0), 32'd1);
                if (sb1.size() != 0) begin
                    e = sb1.pop_front();
                    check("bl1_data", m_data1, e);
                    check("bl1_last", m_last1, 1'b1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain0(input string tag, input int bound);
        int n = 0;
        while (sb0.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        check(tag, sb0.size(), 0);
    endtask

    task automatic wait_beat0(input string tag, input logic [1:0] val, input int bound);
        int n = 0;
        while (beat0 != val && n < bound) begin
            tick();
            n++;
        end
        check(tag, beat0, val);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n    = 1'b0;
        clr0     = 1'b0;
        clr1     = 1'b0;
        m_ready0 = 1'b0;
        m_ready1 = 1'b0;
        #1;
        check("rst_valid", m_valid0, 1'b0);
        check("rst_data", m_data0, 8'h00);
        check("rst_last", m_last0, 1'b0);
        check("rst_beat", beat0, 2'd0);
        check("rst_done", done0, 1'b0);
        check("rst_rd_en", rd_en0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("idle_rd_en", rd_en0, 1'b0);
        check("idle_valid", m_valid0, 1'b0);

        // 1: 8 preloaded words, always ready
        m_ready0 = 1'b1;
        for (int i = 0; i < 8; i++) push0(8'(8'h11 + i));
        #1;
        check("t1_rd_en", rd_en0, 1'b1);
        check("t1_valid_c0", m_valid0, 1'b0);
        tick();
        check("t1_valid_c1", m_valid0, 1'b0);
        tick();
        check("t1_valid_c2", m_valid0, 1'b1);
        check("t1_first_data", m_data0, 8'h11);
        drain0("t1_drain", 20);
        tick();
        tick();
        check("t1_done_cnt", done_cnt0, 2);

        // 2: backpressure pattern 1,0,0
        for (int i = 0; i < 8; i++) push0(8'(8'h21 + i));
        n = 0;
        while (sb0.size() != 0 && n < 100) begin
            m_ready0 = (n % 3 == 0);
            tick();
            n++;
        end
        check("t2_drain", sb0.size(), 0);
        m_ready0 = 1'b1;
        tick();
        tick();
        check("t2_done_cnt", done_cnt0, 4);

        // 3: FIFO runs dry mid-burst, refilled later
        for (int i = 0; i < 3; i++) push0(8'(8'h31 + i));
        drain0("t3_drain_a", 20);
        repeat (5) tick();
        check("t3_gap_valid", m_valid0, 1'b0);
        check("t3_gap_beat", beat0, 2'd3);
        check("t3_gap_last", m_last0, 1'b0);
        check("t3_gap_rd_en", rd_en0, 1'b0);
        push0(8'h34);
        drain0("t3_drain_b", 20);
        tick();
        tick();
        check("t3_done_cnt", done_cnt0, 5);

        // 4: flush while one word is buffered and one is in flight
        for (int i = 0; i < 8; i++) fifo_put0(8'(8'h41 + i));
        expect0(8'h41);
        expect0(8'h42);
        wait_beat0("t4_reach_beat2", 2'd2, 20);
        check("t4_pre_clr_sb", sb0.size(), 0);
        clr0     = 1'b1;
        m_ready0 = 1'b0;
        #1;
        check("t4_clr_rd_en", rd_en0, 1'b0);
        tick();
        clr0     = 1'b0;
        m_ready0 = 1'b1;
        check("t4_post_valid", m_valid0, 1'b0);
        check("t4_post_beat", beat0, 2'd0);
        // 0x43 (buffered) and 0x44 (in flight) are gone
        exp_beat0 = 2'd0;
        for (int i = 0; i < 4; i++) expect0(8'(8'h45 + i));
        drain0("t4_drain", 20);
        tick();
        tick();
        check("t4_done_cnt", done_cnt0, 6);

        // 5: asynchronous reset mid-burst
        for (int i = 0; i < 3; i++) push0(8'(8'h51 + i));
        wait_beat0("t5_reach_beat2", 2'd2, 20);
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", m_valid0, 1'b0);
        check("t5_rst_data", m_data0, 8'h00);
        check("t5_rst_last", m_last0, 1'b0);
        check("t5_rst_beat", beat0, 2'd0);
        check("t5_rst_done", done0, 1'b0);
        check("t5_rst_rd_en", rd_en0, 1'b0);
        sb0.delete();
        exp_beat0 = 2'd0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) push0(8'(8'h54 + i));
        drain0("t5_drain", 20);
        tick();
        tick();
        check("t5_done_cnt", done_cnt0, 7);

        // 6: BURST_LEN = 1
        m_ready1 = 1'b1;
        for (int i = 0; i < 3; i++) push1(8'(8'h61 + i));
        n = 0;
        while (sb1.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        check("t6_drain", sb1.size(), 0);
        tick();
        tick();
        check("t6_done_cnt", done_cnt1, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
